// File: rtl/round_sequencer.sv
// Round sequencer for the shared AES/Keccak round datapath: start/ready/done
// handshake with stall and abort, driving the round index for RC/key lookup.
module round_sequencer #(
    parameter int KECCAK_ROUNDS = 24,
    parameter int AES128_LAST   = 10,
    parameter int AES192_LAST   = 12,
    parameter int AES256_LAST   = 14,
    parameter int CNT_W         = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic             i_stall,
    input  logic             i_abort,
    output logic [CNT_W-1:0] o_round,
    output logic [1:0]       o_mode,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_first,
    output logic             o_last,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_round, w_round_nxt;
    logic [1:0]       r_mode,  w_mode_nxt;
    logic [CNT_W-1:0] w_last;

    // Last index follows the latched mode only, so live i_mode can't move it.
    always_comb begin
        case (r_mode)
            2'b00:   w_last = CNT_W'(AES128_LAST);
            2'b01:   w_last = CNT_W'(AES192_LAST);
            2'b10:   w_last = CNT_W'(AES256_LAST);
            default: w_last = CNT_W'(KECCAK_ROUNDS - 1);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_round <= '0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_mode_nxt  = r_mode;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_round_nxt = '0;
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_mode_nxt  = i_mode;
                    end
                end
                S_RUN: begin
                    if (!i_stall) begin
                        // >= keeps the counter pinned at last even from a corrupted value
                        if (r_round >= w_last) begin
                            w_state_nxt = S_DONE;
                            w_round_nxt = w_last;
                        end else begin
                            w_round_nxt = r_round + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_round_nxt = '0;
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_mode_nxt  = i_mode;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_round_nxt = '0;
                end
            endcase
        end
    end

    assign o_round = r_round;
    assign o_mode  = r_mode;
    assign o_busy  = (r_state == S_RUN);
    assign o_ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign o_first = (r_state == S_RUN) && (r_round == '0);
    assign o_last  = (r_state == S_RUN) && (r_round == w_last);
    assign o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: the driver builds each operation's
// expected cycle trace from the round rules; a negedge monitor pops and compares.
module tb_round_sequencer;

    localparam int KR = 24, A1 = 10, A2 = 12, A3 = 14, CW = 5;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, stall = 1'b0, abort = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] o_round;
    logic [1:0]    o_mode;
    logic          o_busy, o_ready, o_first, o_last, o_done;

    round_sequencer #(
        .KECCAK_ROUNDS(KR), .AES128_LAST(A1), .AES192_LAST(A2),
        .AES256_LAST(A3), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_mode(mode),
        .i_stall(stall), .i_abort(abort), .o_round(o_round), .o_mode(o_mode),
        .o_busy(o_busy), .o_ready(o_ready), .o_first(o_first),
        .o_last(o_last), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] round;
        logic [1:0]    mode;
        logic          busy, ready, first, last, done;
    } obs_t;

    obs_t exp_q[$];
    int   lat_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cyc = 0;

    // Expected architectural view for the current cycle
    int            c_st = ST_IDLE;
    logic [CW-1:0] c_round = '0;
    logic [1:0]    c_mode = 2'b00;

    function automatic int lastidx(logic [1:0] m);
        case (m)
            2'b00:   return A1;
            2'b01:   return A2;
            2'b10:   return A3;
            default: return KR - 1;
        endcase
    endfunction

    function automatic obs_t mk(int st, int r, logic [1:0] m);
        obs_t o;
        o.round = CW'(r);
        o.mode  = m;
        o.busy  = (st == ST_RUN);
        o.ready = (st != ST_RUN);
        o.first = (st == ST_RUN) && (r == 0);
        o.last  = (st == ST_RUN) && (r == lastidx(m));
        o.done  = (st == ST_DONE);
        return o;
    endfunction

    function automatic obs_t sample();
        return {o_round, o_mode, o_busy, o_ready, o_first, o_last, o_done};
    endfunction

    function automatic void chk(string nm, obs_t act, obs_t e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %h want %h (round %0d/%0d mode %0d/%0d)",
                     nm, cyc, act, e, act.round, e.round, act.mode, e.mode);
        end
    endfunction

    // Monitor: per-cycle trace compare plus accept-to-done latency check
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (exp_q.size() != 0) chk("trace", sample(), exp_q.pop_front());
            if (o_done) begin
                n_chk++;
                if (lat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected cyc %0d: got o_done=1 want 0", cyc);
                end else begin
                    int l;
                    l = lat_q.pop_front();
                    if (cyc - acc_cyc != l) begin
                        n_fail++;
                        $display("FAIL latency cyc %0d: got %0d want %0d", cyc, cyc - acc_cyc, l);
                    end
                end
            end
            if (o_ready && start && !abort) acc_cyc = cyc;
        end
    end

    // One cycle: record expectation for the current cycle, drive inputs, advance
    task automatic step(bit s, logic [1:0] m, bit st, bit ab, int nst, int nr, logic [1:0] nm);
        exp_q.push_back(mk(c_st, c_round, c_mode));
        start = s; mode = m; stall = st; abort = ab;
        @(posedge clk); #1;
        c_st = nst; c_round = CW'(nr); c_mode = nm;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 2'($urandom), 1'($urandom), 1'($urandom % 4 == 0), ST_IDLE, 0, c_mode);
    endtask

    // One operation from accept through the final RUN cycle; the DONE cycle is
    // left for the caller (idle or a back-to-back op).
    task automatic op(logic [1:0] m, int stall_pct, int stall_r, int stall_n,
                      int abort_r, int reset_r, bit hold_start);
        int last = lastidx(m);
        int stalls = 0;
        step(1'b1, m, 1'($urandom), 1'b0, ST_RUN, 0, m);
        for (int r = 0; r <= last; r++) begin
            int ns = (r == stall_r) ? stall_n : 0;
            if (r == reset_r) begin
                #1 rst_n = 1'b0;
                #1 chk("async_reset", sample(), mk(ST_IDLE, 0, 2'b00));
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                c_st = ST_IDLE; c_round = '0; c_mode = 2'b00;
                start = 1'b0; stall = 1'b0; abort = 1'b0;
                return;
            end
            while (stall_pct > 0 && ns < 4 && int'($urandom % 100) < stall_pct) ns++;
            for (int k = 0; k < ns; k++) begin
                step(hold_start | 1'($urandom), (r == stall_r) ? 2'b11 : 2'($urandom),
                     1'b1, 1'b0, ST_RUN, r, m);
                stalls++;
            end
            if (r == abort_r) begin
                step(1'b1, 2'b11, 1'b1, 1'b1, ST_IDLE, 0, m);
                return;
            end
            if (r == last) lat_q.push_back(last + 2 + stalls);
            step(hold_start | 1'($urandom), hold_start ? 2'b11 : 2'($urandom), 1'b0, 1'b0,
                 (r == last) ? ST_DONE : ST_RUN, (r == last) ? r : r + 1, m);
        end
    endtask

    initial begin
        #2 chk("reset_state", sample(), mk(ST_IDLE, 0, 2'b00));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        // Keccak, no stall
        op(2'b11, 0, -1, 0, -1, -1, 1'b0); idle(2);
        // AES-128/192/256
        op(2'b00, 0, -1, 0, -1, -1, 1'b0); idle(1);
        op(2'b01, 0, -1, 0, -1, -1, 1'b0); idle(1);
        op(2'b10, 0, -1, 0, -1, -1, 1'b0); idle(2);
        // AES-128 with 3-cycle stall at round 5, i_mode toggled to 11
        op(2'b00, 0, 5, 3, -1, -1, 1'b0); idle(2);
        // Abort with stall and start at Keccak round 9
        op(2'b11, 0, -1, 0, 9, -1, 1'b0); idle(2);
        // Back-to-back AES-256 -> Keccak with start held high
        op(2'b10, 0, -1, 0, -1, -1, 1'b1);
        op(2'b11, 0, -1, 0, -1, -1, 1'b0); idle(2);
        // Asynchronous reset mid-run at round 7
        op(2'b11, 0, -1, 0, -1, 7, 1'b0); idle(2);
        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m = 2'($urandom);
            int ab = ($urandom % 8 == 0) ? int'($urandom % (lastidx(m) + 1)) : -1;
            op(m, int'($urandom % 40), -1, 0, ab, -1, 1'b0);
            if (ab >= 0 || $urandom % 2 == 0) idle(1 + int'($urandom % 3));
        end
        idle(3);
        start = 1'b0; stall = 1'b0; abort = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_chk++;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d trace / %0d done pending want 0", exp_q.size(), lat_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Parametrised round sequencer for the AESHA datapath. It replaces the fixed 0..24 Keccak-only round counter with a single counter that sequences AES-128/192/256 and Keccak-f rounds. It adds a start/ready/done handshake, stall and abort control, and first/last-round flags. It sits between the top-level controller and the shared round datapath, and drives the round index used for round-constant and key-schedule lookup.

## Interface
Parameters:
- KECCAK_ROUNDS, 24: number of Keccak-f rounds; last Keccak index = KECCAK_ROUNDS-1.
- AES128_LAST, 10: final AES-128 round index; round 0 is the initial AddRoundKey.
- AES192_LAST, 12: final AES-192 round index.
- AES256_LAST, 14: final AES-256 round index.
- CNT_W, 5: o_round width; must hold max(KECCAK_ROUNDS-1, AES256_LAST).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_start  in  1  start request; accepted only while o_ready=1.
- i_mode  in  2  mode, sampled on accept: 00 AES-128, 01 AES-192, 10 AES-256, 11 Keccak.
- i_stall  in  1  freezes state, round, mode and flags while high.
- i_abort  in  1  synchronous abort; returns to IDLE.
- o_round  out  CNT_W  current round index.
- o_mode  out  2  latched mode of the current/last operation.
- o_busy  out  1  high in RUN.
- o_ready  out  1  high in IDLE or DONE.
- o_first  out  1  high in RUN when o_round==0.
- o_last  out  1  high in RUN when o_round==last index for o_mode.
- o_done  out  1  one-cycle completion pulse (high in DONE).

## Operation
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registers only; there is no combinational input-to-output path.
- Reset values: state IDLE, o_round 0, o_mode 00. All flags 0 except o_ready=1.
- Accept: o_ready=1 and i_start=1 and i_abort=0. On the next edge: state RUN, o_round 0, o_mode latched from i_mode.
- RUN, i_stall=0, round below last: o_round increments by 1.
- RUN, i_stall=0, o_round==last: state DONE, o_round held at last.
- RUN, i_stall=1: state, o_round and o_mode hold. Flags stay consistent with held values.
- DONE lasts exactly one cycle and is not stallable.
  - Next state is RUN if a start is accepted in DONE (back-to-back; o_round 0, new mode latched).
  - Otherwise next state is IDLE and o_round clears to 0.
- IDLE: o_round held at 0. i_stall has no effect.
- i_abort has priority over i_stall and i_start in every state. Next state is IDLE, o_round 0, o_mode held, no o_done pulse.
- i_start while o_busy=1 is ignored and does not restart.
- The last index is chosen by o_mode (latched), never by live i_mode. i_mode changes during RUN have no effect.
- Round arithmetic is unsigned CNT_W-bit. The counter never exceeds the last index and never wraps.

## Timing
- Latency from start accept to o_done: N+1 cycles with no stalls, where N = last index + 1 rounds. Values: AES-128 12, AES-192 14, AES-256 16, Keccak 25.
- Each stall cycle adds exactly 1 cycle.
- o_first is high in the first RUN cycle. o_last is high in the final RUN cycle. Both are high for every stalled cycle at those indices.
- Back-to-back operation: o_done and the new acceptance share the DONE cycle. The next cycle is RUN with o_round 0, so there are no idle bubbles.
- Asynchronous reset mid-RUN: outputs take reset values immediately, with no o_done pulse.

## Test plan
- Reset: assert i_reset=0 mid-RUN at o_round=7. Required: immediately o_round=0, o_busy=0, o_ready=1, o_done=0.
- Keccak, no stall: i_mode=11, pulse i_start. Required: o_round steps 0..23 on consecutive cycles, o_first at 0, o_last at 23, then a single o_done, then IDLE with o_round=0. Total 25 cycles.
- AES modes: run modes 00, 01, 10 in turn. Required: o_last at o_round 10, 12, 14 respectively, and o_done 12, 14, 16 cycles after accept.
- Stall and mode change: AES-128 with i_stall=1 for 3 cycles at o_round=5, and i_mode toggled to 11 meanwhile. Required: o_round holds 5 for 3 cycles, o_mode stays 00, o_done arrives at cycle 15.
- Abort precedence: i_abort=1 together with i_stall=1 and i_start=1 at Keccak round 9. Required: next cycle IDLE, o_round=0, and no o_done.
- Back-to-back and ignored start: i_start held high across the DONE of an AES-256 run with i_mode=11. Required: the cycle after o_done is RUN, o_round=0, o_mode=11. A start pulse issued at round 3 of that run is ignored.
